phoenix_switchcontrol: RTL and testbench

PHOENIX_SWITCHCONTROL -- requirements
Module: phoenix_switchcontrol

---
 rtl/phoenix_switchcontrol.sv | 209 ++++++++++++++++++++
 tb/tb_phoenix_switchcontrol.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/phoenix_switchcontrol.sv
// phoenix_switchcontrol: switch control for a Phoenix/Hermes NoC router.
// One header request is served per pass of a 4-state FSM
// (S_IDLE -> S_ARB -> S_ROUTE -> S_GRANT) using XY routing. Allocated output
// ports are released when the owning input's sender flag falls.
// Build option: define SWITCHCONTROL_RR_EN for round-robin arbitration;
// the default build uses fixed priority (lowest requesting port wins).
`timescale 1ns/1ps

`ifndef TAM_FLIT
`define TAM_FLIT 8
`endif

module phoenix_switchcontrol #(
  parameter logic [`TAM_FLIT-1:0] ADDRESS = '0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [4:0]             h,
  input  logic [5*`TAM_FLIT-1:0] data,
  input  logic [4:0]             sender,
  output logic [4:0]             ack_h,
  output logic [14:0]            mux_in,
  output logic [14:0]            mux_out,
  output logic [4:0]             free
);

  localparam int FW = `TAM_FLIT;
  localparam int HW = FW / 2;

  localparam logic [2:0] EAST  = 3'd0;
  localparam logic [2:0] WEST  = 3'd1;
  localparam logic [2:0] NORTH = 3'd2;
  localparam logic [2:0] SOUTH = 3'd3;
  localparam logic [2:0] LOCAL = 3'd4;

  localparam logic [HW-1:0] LX = ADDRESS[FW-1:HW];
  localparam logic [HW-1:0] LY = ADDRESS[HW-1:0];

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARB   = 2'd1,
    S_ROUTE = 2'd2,
    S_GRANT = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      sel_q, sel_d;
  logic [2:0]      dest_q, dest_d;
  logic [2:0]      rr_ptr_q, rr_ptr_d;
  logic [4:0]      ack_q, ack_d;
  logic [4:0]      free_q, free_d;
  logic [4:0]      sender_q, sender_d;
  logic [4:0][2:0] mux_in_q, mux_in_d;
  logic [4:0][2:0] mux_out_q, mux_out_d;

  logic [FW-1:0]   hdr;
  logic [2:0]      arb_sel;
  logic [2:0]      route_dest;

`ifdef SWITCHCONTROL_RR_EN
  // Round-robin: search upward from the port after the last winner, wrapping.
  function automatic logic [2:0] arb_pick(input logic [4:0] req, input logic [2:0] ptr);
    logic [2:0] pick;
    logic       found;
    int         idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      idx = (int'(ptr) + k) % 5;
      if (!found && req[idx]) begin
        pick  = 3'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction
`else
  // Fixed priority: lowest requesting index wins.
  function automatic logic [2:0] arb_pick(input logic [4:0] req);
    logic [2:0] pick;
    logic       found;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (!found && req[k]) begin
        pick  = 3'(k);
        found = 1'b1;
      end
    end
    return pick;
  endfunction
`endif

  // XY routing: resolve X first, then Y; equal coordinates mean this router.
  function automatic logic [2:0] xy_route(input logic [FW-1:0] flit);
    logic [HW-1:0] tx, ty;
    logic [2:0]    d;
    tx = flit[FW-1:HW];
    ty = flit[HW-1:0];
    if (tx > LX)      d = EAST;
    else if (tx < LX) d = WEST;
    else if (ty > LY) d = NORTH;
    else if (ty < LY) d = SOUTH;
    else              d = LOCAL;
    return d;
  endfunction

`ifdef SWITCHCONTROL_RR_EN
  assign arb_sel = arb_pick(h, rr_ptr_q);
`else
  assign arb_sel = arb_pick(h);
`endif

  // Header flit of the selected input port.
  always_comb begin
    hdr = data[FW-1:0];
    for (int i = 0; i < 5; i++) begin
      if (sel_q == 3'(i)) hdr = data[i*FW +: FW];
    end
  end

  assign route_dest = xy_route(hdr);

  // Next-state logic: release of finished connections, then the FSM step.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    dest_d    = dest_q;
    rr_ptr_d  = rr_ptr_q;
    ack_d     = '0;
    free_d    = free_q;
    mux_in_d  = mux_in_q;
    mux_out_d = mux_out_q;
    sender_d  = sender;

    // A falling sender on the owning input ends the packet and frees the output.
    for (int o = 0; o < 5; o++) begin
      if (!free_q[o] && sender_q[mux_in_q[o]] && !sender[mux_in_q[o]])
        free_d[o] = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (|h) state_d = S_ARB;
      end
      S_ARB: begin
        // Requests may vanish between S_IDLE and S_ARB; never select an idle port.
        if (|h) begin
          sel_d = arb_sel;
`ifdef SWITCHCONTROL_RR_EN
          rr_ptr_d = arb_sel;
`endif
          state_d = S_ROUTE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ROUTE: begin
        // Uses the registered free vector, so a same-edge release reads as busy.
        dest_d = route_dest;
        if (free_q[route_dest]) begin
          ack_d   = 5'b00001 << sel_q;
          state_d = S_GRANT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GRANT: begin
        // Written after the release loop so a same-edge grant wins.
        free_d[dest_q]   = 1'b0;
        mux_in_d[dest_q] = sel_q;
        mux_out_d[sel_q] = dest_q;
        state_d          = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs; reset overrides every update.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      sel_q     <= '0;
      dest_q    <= '0;
      rr_ptr_q  <= 3'd4;
      ack_q     <= '0;
      free_q    <= 5'b11111;
      sender_q  <= '0;
      mux_in_q  <= '0;
      mux_out_q <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      dest_q    <= dest_d;
      rr_ptr_q  <= rr_ptr_d;
      ack_q     <= ack_d;
      free_q    <= free_d;
      sender_q  <= sender_d;
      mux_in_q  <= mux_in_d;
      mux_out_q <= mux_out_d;
    end
  end

  assign ack_h   = ack_q;
  assign free    = free_q;
  assign mux_in  = mux_in_q;
  assign mux_out = mux_out_q;

endmodule

// File: tb/tb_phoenix_switchcontrol.sv
// Testbench for phoenix_switchcontrol (TAM_FLIT=8, ADDRESS=8'h11).
// Expected grants are queued when requests are driven and compared when
// ack_h appears.
`timescale 1ns/1ps

module tb_phoenix_switchcontrol;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  h;
  logic [39:0] data;
  logic [4:0]  sender;
  logic [4:0]  ack_h;
  logic [14:0] mux_in;
  logic [14:0] mux_out;
  logic [4:0]  free;

  typedef struct {
    int port;
    int dest;
  } grant_t;

  grant_t exp_q[$];
  int     n_chk  = 0;
  int     n_pass = 0;
  int     cyc;
  logic [4:0] acc;

  phoenix_switchcontrol #(.ADDRESS(8'h11)) dut (
    .clock   (clock),
    .reset   (reset),
    .h       (h),
    .data    (data),
    .sender  (sender),
    .ack_h   (ack_h),
    .mux_in  (mux_in),
    .mux_out (mux_out),
    .free    (free)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic expect_grant(input int port, input int dest);
    grant_t e;
    e.port = port;
    e.dest = dest;
    exp_q.push_back(e);
  endtask

  task automatic request(input int port, input logic [7:0] hdr);
    data[port*8 +: 8] = hdr;
    h[port] = 1'b1;
  endtask

  // Wait for the next ack_h pulse and score it against the queue head.
  task automatic wait_grant(input int budget, output int ncyc);
    grant_t e;
    bit     seen;
    ncyc = 0;
    seen = 0;
    while (!seen && ncyc < budget) begin
      @(negedge clock);
      ncyc++;
      if (ack_h != 5'b0) seen = 1;
    end
    if (!seen) begin
      check("ack_timeout", 32'd0, 32'd1);
      return;
    end
    for (int i = 0; i < 5; i++) if (ack_h[i]) h[i] = 1'b0;
    if (exp_q.size() == 0) begin
      check("unexpected_ack", 32'(ack_h), 32'd0);
      return;
    end
    e = exp_q.pop_front();
    check("ack_port", 32'(ack_h), 32'(1) << e.port);
    @(negedge clock);
    check("ack_one_cycle", 32'(ack_h), 32'd0);
    check("free_dest", 32'(free[e.dest]), 32'd0);
    check("mux_in", 32'(mux_in[3*e.dest +: 3]), 32'(e.port));
    check("mux_out", 32'(mux_out[3*e.port +: 3]), 32'(e.dest));
  endtask

  // One packet's sender high then low; returns one negedge after the fall edge.
  task automatic pulse_sender(input int port);
    sender[port] = 1'b1;
    @(negedge clock);
    sender[port] = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] hdrs [5];
    int         dests [5];
    hdrs  = '{8'h21, 8'h10, 8'h11, 8'h12, 8'h01};
    dests = '{0, 3, 4, 2, 1};

    h = '0; sender = '0; data = '0; reset = 1'b1;
    repeat (2) @(negedge clock);
    check("rst_free", 32'(free), 32'h1f);
    check("rst_ack", 32'(ack_h), 32'd0);
    check("rst_mux_in", 32'(mux_in), 32'd0);
    check("rst_mux_out", 32'(mux_out), 32'd0);
    reset = 1'b0;

    // Single requests from LOCAL to every destination, with release.
    for (int i = 0; i < 5; i++) begin
      request(4, hdrs[i]);
      expect_grant(4, dests[i]);
      wait_grant(10, cyc);
      check("latency", 32'(cyc), 32'd3);
      check("free_alloc", 32'(free), 32'h1f & ~(32'(1) << dests[i]));
      pulse_sender(4);
      check("free_release", 32'(free), 32'h1f);
    end

    // Contested arbitration: port 0 keeps requesting after its first grant.
    request(0, 8'h21);
    request(2, 8'h12);
    expect_grant(0, 0);
`ifdef SWITCHCONTROL_RR_EN
    expect_grant(2, 2);
    expect_grant(0, 3);
`else
    expect_grant(0, 3);
    expect_grant(2, 2);
`endif
    wait_grant(20, cyc);
    request(0, 8'h10);
    wait_grant(20, cyc);
    wait_grant(20, cyc);
    check("free_three_alloc", 32'(free), 32'b10010);
    pulse_sender(0);
    check("multi_release", 32'(free), 32'b11011);
    pulse_sender(2);
    check("free_all_back", 32'(free), 32'h1f);

    // Busy output: WEST waits for EAST held by LOCAL.
    request(4, 8'h21);
    expect_grant(4, 0);
    wait_grant(10, cyc);
    sender[4] = 1'b1;
    request(1, 8'h21);
    expect_grant(1, 0);
    acc = '0;
    repeat (20) begin
      @(negedge clock);
      acc = acc | ack_h;
    end
    check("no_ack_busy", 32'(acc), 32'd0);
    check("free_busy", 32'(free), 32'b11110);
    sender[4] = 1'b0;
    wait_grant(20, cyc);
    check("free_after_retry", 32'(free), 32'b11110);
    pulse_sender(1);
    check("free_retry_release", 32'(free), 32'h1f);

    // Reset while a request is about to be granted, with EAST allocated.
    request(4, 8'h21);
    expect_grant(4, 0);
    wait_grant(10, cyc);
    request(3, 8'h12);
    @(negedge clock);
    @(negedge clock);
    check("pre_rst_ack", 32'(ack_h), 32'd0);
    reset = 1'b1;
    @(negedge clock);
    check("rst_mid_ack", 32'(ack_h), 32'd0);
    check("rst_mid_free", 32'(free), 32'h1f);
    check("rst_mid_mux_in", 32'(mux_in), 32'd0);
    reset = 1'b0;
    expect_grant(3, 2);
    wait_grant(20, cyc);
    check("latency_after_rst", 32'(cyc), 32'd3);
    pulse_sender(3);
    check("free_final", 32'(free), 32'h1f);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
